seq_mult: RTL and testbench



---
 rtl/mult_pkg.sv | 9 +
 rtl/mult_step.sv | 19 +
 rtl/seq_mult.sv | 105 ++++++++++
 tb/tb_seq_mult.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states, mode encodings and cycle-count helper for the iterative multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;
    function automatic int calc_n(input int width, input int bpc);
        return width / bpc;
    endfunction
endpackage

// File: rtl/mult_step.sv
// mult_step: one radix-2^BITS_PER_CYCLE add/shift slice of the shift-add multiplier
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH:0]  acc_in,
    input  logic [WIDTH-1:0]  mcnd,
    output logic [2*WIDTH:0]  acc_out
);
    always_comb begin
        acc_out = acc_in;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            acc_out[2*WIDTH:WIDTH] = acc_out[0] ? acc_out[2*WIDTH:WIDTH] + {1'b0, mcnd} : acc_out[2*WIDTH:WIDTH];
            acc_out = acc_out >> 1;
        end
    end
endmodule

// File: rtl/seq_mult.sv
// seq_mult: iterative signed/unsigned shift-add multiplier with start/busy/done handshake
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     data_a,
    input  logic [WIDTH-1:0]     data_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);
    localparam int N  = calc_n(WIDTH, BITS_PER_CYCLE);
    localparam int CW = $clog2(N + 1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
        $error("seq_mult: illegal BITS_PER_CYCLE for WIDTH");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcnd_q, mcnd_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH:0]   acc_q, acc_d, step_acc;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    mult_step #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .acc_in (acc_q),
        .mcnd   (mcnd_q),
        .acc_out(step_acc)
    );

    // The most-negative operand negates to itself, which is its correct unsigned magnitude.
    assign a_neg = (signed_mode == MODE_SIGNED) && data_a[WIDTH-1];
    assign b_neg = (signed_mode == MODE_SIGNED) && data_b[WIDTH-1];
    assign a_mag = a_neg ? -data_a : data_a;
    assign b_mag = b_neg ? -data_b : data_b;

    always_comb begin
        state_d  = state_q;
        mcnd_d   = mcnd_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                mcnd_d  = a_mag;
                neg_d   = a_neg ^ b_neg;
                acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
                count_d = '0;
                busy_d  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                acc_d   = step_acc;
                count_d = count_q + CW'(1);
                state_d = (count_q == CW'(N - 1)) ? FIN : RUN;
            end
            FIN: begin
                result_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcnd_q   <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcnd_q   <= mcnd_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed table plus handshake sequences for the 32-bit multiplier and a W=8 sweep over BITS_PER_CYCLE
module tb_seq_mult;
    import mult_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, sm = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [63:0] result;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  busy8, done8;
    logic [15:0] res8 [3];
    int          pass_n = 0, total = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(sm),
        .data_a(a), .data_b(b), .busy(busy), .done(done), .result(result)
    );

    for (genvar g = 0; g < 3; g++) begin : g_w8
        seq_mult #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) u (
            .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
            .data_a(a8), .data_b(b8), .busy(busy8[g]), .done(done8[g]), .result(res8[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run32(input logic s, input logic [31:0] x, input logic [31:0] y, input int inject_at,
                         output logic [63:0] res, output int lat, output int bcnt);
        sm = s; a = x; b = y; start = 1'b1;
        cyc();
        start = 1'b0; a = ~x; b = y ^ 32'h5a5a5a5a; sm = ~s;
        lat = 0; bcnt = 0;
        while (!done && lat < 60) begin
            bcnt += int'(busy);
            start = (inject_at > 0 && lat == inject_at);
            if (start) begin a = 32'd3; b = 32'd3; end
            cyc();
            lat++;
        end
        start = 1'b0;
        res = result;
    endtask

    task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y);
        int lat [3];
        int sa, sb;
        logic [15:0] exp;
        sm8 = s; a8 = x; b8 = y; start8 = 1'b1;
        cyc();
        start8 = 1'b0; a8 = ~x; b8 = ~y;
        lat = '{0, 0, 0};
        for (int c = 1; c <= 15; c++) begin
            cyc();
            for (int g = 0; g < 3; g++) if (done8[g] && lat[g] == 0) lat[g] = c;
        end
        sa = s ? int'($signed(x)) : int'(x);
        sb = s ? int'($signed(y)) : int'(y);
        exp = 16'(sa * sb);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("w8 bpc%0d m%0d %h*%h result", 1 << g, s, x, y), 64'(res8[g]), 64'(exp));
            chk($sformatf("w8 bpc%0d latency", 1 << g), 64'(lat[g]), 64'(8 / (1 << g) + 1));
        end
    endtask

    typedef struct {
        logic        s;
        logic [31:0] x, y;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t        vt [10];
        logic [63:0] res, res2;
        int          lat, bcnt, seen;
        logic [7:0]  cx [5];
        logic [7:0]  cy [5];

        vt[0] = '{MODE_UNSIGNED, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vt[1] = '{MODE_SIGNED,   32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFFFFFFFFEB};
        vt[2] = '{MODE_SIGNED,   32'h80000000, 32'h80000000, 64'h4000000000000000};
        vt[3] = '{MODE_UNSIGNED, 32'h80000000, 32'h00000002, 64'h0000000100000000};
        vt[4] = '{MODE_UNSIGNED, 32'h00000000, 32'h12345678, 64'h0000000000000000};
        vt[5] = '{MODE_UNSIGNED, 32'h00000001, 32'hDEADBEEF, 64'h00000000DEADBEEF};
        vt[6] = '{MODE_SIGNED,   32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        vt[7] = '{MODE_SIGNED,   32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000};
        vt[8] = '{MODE_SIGNED,   32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
        vt[9] = '{MODE_SIGNED,   32'h00000005, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFEC};

        repeat (3) cyc();
        reset = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset w8 result", 64'(res8[0]), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run32(vt[i].s, vt[i].x, vt[i].y, 0, res, lat, bcnt);
            chk($sformatf("v%0d result", i), res, vt[i].exp);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'd33);
            chk($sformatf("v%0d busy cycles", i), 64'(bcnt), 64'd33);
            cyc();
            chk($sformatf("v%0d done pulse width", i), 64'(done), 64'd0);
            chk($sformatf("v%0d result held", i), result, vt[i].exp);
        end

        run32(MODE_UNSIGNED, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, res, lat, bcnt);
        chk("start while busy result", res, 64'hFFFFFFFE00000001);
        chk("start while busy latency", 64'(lat), 64'd33);

        run32(MODE_SIGNED, 32'hFFFFFFFD, 32'd7, 0, res, lat, bcnt);
        run32(MODE_UNSIGNED, 32'h80000000, 32'd2, 0, res2, lat, bcnt);
        chk("back-to-back first", res, 64'hFFFFFFFFFFFFFFEB);
        chk("back-to-back second", res2, 64'h0000000100000000);
        chk("back-to-back latency", 64'(lat), 64'd33);

        sm = MODE_UNSIGNED; a = 32'd5; b = 32'd6; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        chk("mid-run busy", 64'(busy), 64'd1);
        chk("mid-run result held", result, 64'h0000000100000000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort result", result, 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen = 1;
            cyc();
        end
        chk("abort no done", 64'(seen), 64'd0);

        reset = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
        cyc();
        reset = 1'b0; start = 1'b0;
        chk("reset beats start busy", 64'(busy), 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) seen = 1;
            cyc();
        end
        chk("reset beats start idle", 64'(seen), 64'd0);

        run32(MODE_SIGNED, 32'h80000000, 32'h80000000, 0, res, lat, bcnt);
        chk("after reset result", res, 64'h4000000000000000);

        cx = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01};
        cy = '{8'h80, 8'hFF, 8'h80, 8'hFF, 8'h80};
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 5; i++) run8(m[0], cx[i], cy[i]);
            for (int i = 0; i < 120; i++) run8(m[0], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule
